mul_seq_ctrl: RTL and testbench
===============================

// Module: mul_seq_ctrl
// PURPOSE
//  Multi-cycle controller that computes an OP_W x OP_W unsigned product using one
//  shared 4x4 array multiplier (four_bitarrmul). Each cycle it feeds one digit pair
//  into the multiplier and adds the shifted partial product into an accumulator.
//  It sits between a valid/ready operand source and a valid/ready result sink, and
//  is the team's standard way to get wide products without replicating the array.
// PARAMETERS
//  OP_W    8   operand width in bits; must be a multiple of 4 and >= 8
//  DIG_W   4   digit width, fixed to match four_bitarrmul (localparam, not overridable)
//  NDIG    OP_W/4   digits per operand (localparam)
//  NSTEP   NDIG*NDIG   multiply steps per operation (localparam)
// PORTS
//  clk        in   1        single clock, rising edge
//  rst_n      in   1        asynchronous, active-low reset
//  in_valid   in   1        operand pair valid
//  in_ready   out  1        controller can accept operands
//  a          in   OP_W     multiplicand, unsigned
//  b          in   OP_W     multiplier, unsigned
//  out_valid  out  1        product valid
//  out_ready  in   1        sink accepts product
//  p          out  2*OP_W   product a*b, unsigned, exact (no truncation)
//  busy       out  1        high in any state other than IDLE
// BEHAVIOUR
//  Reset (rst_n=0, async): state=IDLE, step=0, acc=0, a_q=b_q=0.
//   Outputs then: in_ready=1, out_valid=0, busy=0, p=0.
//  FSM: IDLE -> MUL on in_valid&in_ready. MUL -> DONE on the edge that retires
//   step NSTEP-1. DONE -> IDLE on out_valid&out_ready.
//  IDLE: in_ready=1. On accept: latch a_q=a, b_q=b, clear acc, step=0.
//  MUL: step = i*NDIG + j, with i = step/NDIG (a digit) and j = step%NDIG (b digit).
//   Multiplier inputs are a_q[4i+:4] and b_q[4j+:4].
//   On each edge: acc <= acc + (pp8 << 4*(i+j)) and step <= step+1.
//   Accumulator is 2*OP_W bits. Max sum == (2^OP_W-1)^2, so no overflow is possible.
//  DONE: out_valid=1 and p=acc. Both are held stable until out_ready=1.
//  Latency: out_valid rises exactly NSTEP cycles after the accept edge (OP_W=8 -> 4).
//  Throughput: one result per NSTEP+2 cycles at best.
//   in_ready is low in MUL and DONE.
//   No accept in the same cycle as result handoff; IDLE always has one bubble.
//  in_valid while busy: ignored. The source must hold a/b/in_valid until in_ready.
//  out_ready while not DONE: ignored.
//  Operand changes on a/b after accept: no effect (latched copies are used).
//  Reset mid-MUL or mid-DONE: the operation and any pending result are discarded.
//   Return to IDLE immediately; no partial result is ever presented.
//  step counter: clog2(NSTEP) bits. Never wraps, because MUL exits at NSTEP-1.
//  p outside DONE: holds the last acc value. It is valid only when out_valid=1.
// STRUCTURE
//  Package mul_seq_pkg:
//   - state enum {IDLE, MUL, DONE}
//   - DIG_W=4 constant
//   - function step_shift(step, ndig) returning 4*(i+j)
//  Sub-module: exactly one instance of four_bitarrmul (combinational, 4x4 -> 8).
//  Remaining logic in this module:
//   - FSM
//   - step counter
//   - operand registers
//   - digit mux
//   - shifter
//   - accumulator adder
// TESTING
//  T1 OP_W=8: a=0x12, b=0x34 accepted at cycle 0.
//   -> out_valid at cycle 4, p=0x03A8, busy=1 in cycles 1-4.
//  T2 OP_W=8: a=0xFF, b=0xFF -> p=0xFE01. Also a=0x00, b=0xAB -> p=0x0000 after 4 cycles.
//  T3 back-pressure: a=0x0F, b=0x0B, out_ready low 3 cycles after out_valid.
//   -> p=0x00A5 held stable, in_ready=0 throughout.
//   -> in_ready=1 the cycle after the handshake.
//  T4 async reset: rst_n=0 mid-MUL (step 2) with a=0xAA, b=0x55.
//   -> immediate IDLE, out_valid=0, p=0.
//   -> next op a=0x03, b=0x05 gives p=0x000F.
//  T5 OP_W=16: a=0xFFFF, b=0xFFFF.
//   -> out_valid 16 cycles after accept, p=0xFFFE0001.
//  T6 protocol: toggle in_valid and change a/b during MUL -> result unaffected.
//   Random 1000-op sweep vs a*b reference model, with random out_ready.

Source files
------------

// File: rtl/mul_seq_ctrl_pkg.sv
// Shared types and helpers for the digit-serial multiply controller.
package mul_seq_pkg;

  typedef enum logic [1:0] {IDLE, MUL, DONE} state_e;

  localparam int unsigned DIG_W = 4;

  // Step walks a-digit i (outer) and b-digit j (inner); the partial product weight is 4*(i+j).
  function automatic int unsigned step_shift(input int unsigned step, input int unsigned ndig);
    return DIG_W * (step / ndig + step % ndig);
  endfunction

endpackage

// File: rtl/mul_seq_ctrl_if.sv
// Operand and result valid/ready channels of the multiply controller.
interface mul_seq_ctrl_if #(parameter int unsigned OP_W = 8);

  logic              in_valid;
  logic              in_ready;
  logic [OP_W-1:0]   a;
  logic [OP_W-1:0]   b;
  logic              out_valid;
  logic              out_ready;
  logic [2*OP_W-1:0] p;

  modport master (output in_valid, a, b, out_ready, input in_ready, out_valid, p);
  modport slave  (input in_valid, a, b, out_ready, output in_ready, out_valid, p);

endinterface

// File: rtl/mul_seq_ctrl_four_bitarrmul.sv
// Combinational 4x4 unsigned array multiplier: one AND row per multiplier bit.
module four_bitarrmul (
  input  logic [3:0] a_i,
  input  logic [3:0] b_i,
  output logic [7:0] p_o
);

  logic [3:0] b_sh;

  always_comb begin
    p_o  = '0;
    b_sh = '0;
    for (int unsigned r = 0; r < 4; r++) begin
      b_sh = b_i >> r;
      p_o  = p_o + ({4'b0000, a_i & {4{b_sh[0]}}} << r);
    end
  end

endmodule

// File: rtl/mul_seq_ctrl.sv
// Multi-cycle OP_W x OP_W unsigned multiplier built around one shared 4x4 array,
// accumulating one shifted digit-pair partial product per cycle.
module mul_seq_ctrl
  import mul_seq_pkg::*;
#(
  parameter int unsigned OP_W = 8
) (
  input  logic          clk,
  input  logic          rst_n,
  mul_seq_ctrl_if.slave bus,
  output logic          busy
);

  localparam int unsigned NDIG   = OP_W / DIG_W;
  localparam int unsigned NSTEP  = NDIG * NDIG;
  localparam int unsigned STEP_W = $clog2(NSTEP);
  localparam int unsigned P_W    = 2 * OP_W;

  state_e                state_q, state_d;
  logic [STEP_W-1:0]     step_q, step_d;
  logic [P_W-1:0]        acc_q, acc_d;
  logic [OP_W-1:0]       a_q, a_d, b_q, b_d;
  logic [DIG_W-1:0]      a_dig, b_dig;
  logic [2*DIG_W-1:0]    pp;
  logic [P_W-1:0]        pp_shifted;
  int unsigned           dig_i, dig_j;

  // Digit mux via shift-and-truncate keeps the select width-agnostic for any NDIG.
  always_comb begin
    dig_i      = 32'(step_q) / NDIG;
    dig_j      = 32'(step_q) % NDIG;
    a_dig      = DIG_W'(a_q >> (DIG_W * dig_i));
    b_dig      = DIG_W'(b_q >> (DIG_W * dig_j));
    pp_shifted = P_W'(pp) << step_shift(32'(step_q), NDIG);
  end

  four_bitarrmul u_arrmul (
    .a_i (a_dig),
    .b_i (b_dig),
    .p_o (pp)
  );

  always_comb begin
    state_d = state_q;
    step_d  = step_q;
    acc_d   = acc_q;
    a_d     = a_q;
    b_d     = b_q;
    unique case (state_q)
      IDLE: begin
        if (bus.in_valid) begin
          a_d     = bus.a;
          b_d     = bus.b;
          acc_d   = '0;
          step_d  = '0;
          state_d = MUL;
        end
      end
      MUL: begin
        acc_d  = acc_q + pp_shifted;
        step_d = step_q + 1'b1;
        if (step_q == STEP_W'(NSTEP - 1)) state_d = DONE;
      end
      DONE: begin
        if (bus.out_ready) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
      step_q  <= '0;
      acc_q   <= '0;
      a_q     <= '0;
      b_q     <= '0;
    end else begin
      state_q <= state_d;
      step_q  <= step_d;
      acc_q   <= acc_d;
      a_q     <= a_d;
      b_q     <= b_d;
    end
  end

  assign bus.in_ready  = (state_q == IDLE);
  assign bus.out_valid = (state_q == DONE);
  assign bus.p         = acc_q;
  assign busy          = (state_q != IDLE);

endmodule

// File: tb/tb_mul_seq_ctrl.sv
// Randomized self-checking bench for mul_seq_ctrl at OP_W=8 and OP_W=16 against a*b.
module tb_mul_seq_ctrl;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  logic busy8, busy16;
  int   vectors = 0;
  int   miscompares = 0;

  mul_seq_ctrl_if #(.OP_W(8))  bus8 ();
  mul_seq_ctrl_if #(.OP_W(16)) bus16 ();

  mul_seq_ctrl #(.OP_W(8))  u_dut8  (.clk(clk), .rst_n(rst_n), .bus(bus8),  .busy(busy8));
  mul_seq_ctrl #(.OP_W(16)) u_dut16 (.clk(clk), .rst_n(rst_n), .bus(bus16), .busy(busy16));

  always #5 clk = ~clk;

  // One full 8-bit operation; hold<0 means random out_ready, wiggle disturbs inputs during MUL.
  task automatic run_op8(input logic [7:0] a, input logic [7:0] b, input int hold, input bit wiggle);
    logic [15:0] expv;
    int          lat, held;
    logic        rd;
    expv = 16'(a) * 16'(b);
    @(negedge clk);
    bus8.in_valid = 1'b1; bus8.a = a; bus8.b = b; bus8.out_ready = 1'b0;
    vectors++;
    if (bus8.in_ready !== 1'b1) begin
      miscompares++; $display("FAIL in_ready_idle: got %b expected 1", bus8.in_ready);
    end
    @(negedge clk);
    bus8.in_valid = 1'b0;
    lat = 0;
    while (bus8.out_valid !== 1'b1 && lat < 50) begin
      vectors++;
      if (busy8 !== 1'b1) begin
        miscompares++; $display("FAIL busy_mul: got %b expected 1 at cycle %0d", busy8, lat);
      end
      if (wiggle) begin
        bus8.in_valid  = 1'($urandom);
        bus8.a         = 8'($urandom);
        bus8.b         = 8'($urandom);
        bus8.out_ready = 1'($urandom);
      end
      @(negedge clk);
      lat++;
    end
    bus8.in_valid = 1'b0;
    vectors++;
    if (lat != 4) begin
      miscompares++; $display("FAIL latency: got %0d expected 4", lat);
    end
    held = 0;
    rd   = 1'b0;
    while (!rd && held < 50) begin
      vectors++;
      if (bus8.p !== expv || bus8.out_valid !== 1'b1 || bus8.in_ready !== 1'b0 || busy8 !== 1'b1) begin
        miscompares++;
        $display("FAIL done_hold: p=%h ov=%b ir=%b busy=%b expected p=%h ov=1 ir=0 busy=1 (a=%h b=%h)",
                 bus8.p, bus8.out_valid, bus8.in_ready, busy8, expv, a, b);
      end
      rd = (hold < 0) ? 1'($urandom) : (held >= hold);
      bus8.out_ready = rd;
      @(negedge clk);
      held++;
    end
    bus8.out_ready = 1'b0;
    vectors++;
    if (bus8.out_valid !== 1'b0 || bus8.in_ready !== 1'b1 || busy8 !== 1'b0 || bus8.p !== expv) begin
      miscompares++;
      $display("FAIL post_handoff: ov=%b ir=%b busy=%b p=%h expected ov=0 ir=1 busy=0 p=%h",
               bus8.out_valid, bus8.in_ready, busy8, bus8.p, expv);
    end
    if (hold >= 0) begin
      vectors++;
      if (held != hold + 1) begin
        miscompares++; $display("FAIL hold_cycles: got %0d expected %0d", held, hold + 1);
      end
    end
  endtask

  task automatic test_reset();
    bus8.in_valid = 1'b0; bus8.a = '0; bus8.b = '0; bus8.out_ready = 1'b0;
    bus16.in_valid = 1'b0; bus16.a = '0; bus16.b = '0; bus16.out_ready = 1'b0;
    rst_n = 1'b0;
    repeat (2) @(negedge clk);
    vectors++;
    if (bus8.in_ready !== 1'b1 || bus8.out_valid !== 1'b0 || busy8 !== 1'b0 || bus8.p !== 16'h0) begin
      miscompares++;
      $display("FAIL reset8: ir=%b ov=%b busy=%b p=%h expected 1 0 0 0000", bus8.in_ready, bus8.out_valid, busy8, bus8.p);
    end
    vectors++;
    if (bus16.in_ready !== 1'b1 || bus16.out_valid !== 1'b0 || busy16 !== 1'b0 || bus16.p !== 32'h0) begin
      miscompares++;
      $display("FAIL reset16: ir=%b ov=%b busy=%b p=%h expected 1 0 0 0", bus16.in_ready, bus16.out_valid, busy16, bus16.p);
    end
    rst_n = 1'b1;
  endtask

  task automatic test_basic();
    run_op8(8'h12, 8'h34, 0, 1'b0);
    run_op8(8'hFF, 8'hFF, 0, 1'b0);
    run_op8(8'h00, 8'hAB, 0, 1'b0);
  endtask

  task automatic test_backpressure();
    run_op8(8'h0F, 8'h0B, 3, 1'b0);
  endtask

  task automatic test_async_reset();
    @(negedge clk);
    bus8.in_valid = 1'b1; bus8.a = 8'hAA; bus8.b = 8'h55;
    @(negedge clk);
    bus8.in_valid = 1'b0;
    repeat (2) @(negedge clk);
    #2 rst_n = 1'b0;
    #1;
    vectors++;
    if (bus8.in_ready !== 1'b1 || bus8.out_valid !== 1'b0 || busy8 !== 1'b0 || bus8.p !== 16'h0) begin
      miscompares++;
      $display("FAIL async_reset: ir=%b ov=%b busy=%b p=%h expected 1 0 0 0000", bus8.in_ready, bus8.out_valid, busy8, bus8.p);
    end
    @(negedge clk);
    rst_n = 1'b1;
    run_op8(8'h03, 8'h05, 0, 1'b0);
  endtask

  task automatic test_wide();
    logic [15:0] a, b;
    logic [31:0] expv;
    int          lat;
    for (int n = 0; n < 4; n++) begin
      a = (n == 0) ? 16'hFFFF : 16'($urandom);
      b = (n == 0) ? 16'hFFFF : 16'($urandom);
      expv = 32'(a) * 32'(b);
      @(negedge clk);
      bus16.in_valid = 1'b1; bus16.a = a; bus16.b = b;
      @(negedge clk);
      bus16.in_valid = 1'b0;
      bus16.a = 16'($urandom);
      lat = 0;
      while (bus16.out_valid !== 1'b1 && lat < 100) begin
        @(negedge clk);
        lat++;
      end
      vectors++;
      if (lat != 16) begin
        miscompares++; $display("FAIL wide_latency: got %0d expected 16", lat);
      end
      vectors++;
      if (bus16.p !== expv) begin
        miscompares++; $display("FAIL wide_product: got %h expected %h (a=%h b=%h)", bus16.p, expv, a, b);
      end
      bus16.out_ready = 1'b1;
      @(negedge clk);
      bus16.out_ready = 1'b0;
      vectors++;
      if (bus16.in_ready !== 1'b1 || busy16 !== 1'b0) begin
        miscompares++; $display("FAIL wide_handoff: ir=%b busy=%b expected 1 0", bus16.in_ready, busy16);
      end
    end
  endtask

  task automatic test_random_sweep();
    for (int n = 0; n < 1000; n++)
      run_op8(8'($urandom), 8'($urandom), -1, 1'b1);
  endtask

  initial begin
    test_reset();
    test_basic();
    test_backpressure();
    test_async_reset();
    test_wide();
    test_random_sweep();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
